mc_core: RTL
============

# mc_core

Parametrised multicycle MIPS-subset core combining control FSM, register file, ALU and PC sequencing in a single block. It is the next-generation top of the processor: configurable data width, register count and address width, separate instruction/data ports with req/ack handshakes so memories may insert wait states, and a sticky `done` flag raised by a HALT instruction. It drives `out` with the most recent register write-back value for board/bench observation.

## Interface
- DATA_W, 16, datapath and register width (≥8)
- NREG, 8, register count (power of 2, ≤32); register index = low log2(NREG) bits of rs/rt/rd fields
- ADDR_W, 10, word address width of both memory ports
- clk  in  1  clock, all state on rising edge
- reset  in  1  asynchronous, active-low reset (low = reset asserted)
- imem_req  out  1  instruction fetch request, held until ack
- imem_addr  out  ADDR_W  fetch word address (= PC)
- imem_ack  in  1  fetch complete; imem_rdata valid this cycle
- imem_rdata  in  32  instruction word, MIPS field layout
- dmem_req  out  1  data access request, held until ack
- dmem_we  out  1  1 = store, 0 = load; stable while req high
- dmem_addr  out  ADDR_W  data word address
- dmem_wdata  out  DATA_W  store data
- dmem_ack  in  1  access complete; dmem_rdata valid this cycle on load
- dmem_rdata  in  DATA_W  load data
- out  out  DATA_W  last value written to register file
- done  out  1  high once HALT executed, sticky until reset

## Operation
- ISA: opcode 0x00 R-type with func 0x20 add, 0x22 sub, 0x24 and, 0x25 or, 0x2A slt (signed, result 1/0); 0x08 addi; 0x23 lw; 0x2B sw; 0x04 beq; 0x02 j; 0x3F halt. Any other opcode/func: no-op, PC+1.
- Immediate: 16-bit field sign-extended, then truncated/extended to DATA_W; all arithmetic modulo 2^DATA_W.
- Address: lw/sw address = (rs + imm)[ADDR_W-1:0] (zero-extended if DATA_W < ADDR_W).
- PC: ADDR_W-bit word address, reset 0; sequential PC+1 wraps to 0; beq taken PC = PC+1+imm (mod 2^ADDR_W); j PC = target[ADDR_W-1:0].
- Register 0 reads 0; writes to it discarded, and do not update `out`.
- States: FETCH, DECODE, EXEC, MEM, WB, HALT.
  - FETCH: imem_req=1; on imem_ack latch IR, PC<=PC+1, -> DECODE.
  - DECODE: read rs/rt into A/B; j loads PC -> FETCH; halt -> HALT; unknown -> FETCH; else -> EXEC.
  - EXEC: ALU op; beq updates PC if A==B -> FETCH; lw/sw -> MEM; R-type/addi -> WB.
  - MEM: dmem_req=1; on dmem_ack: sw -> FETCH; lw latches rdata -> WB.
  - WB: write rd (R-type) or rt (addi/lw); out<=written value -> FETCH.
  - HALT: done=1, no requests, remains until reset.
- Only one port requests at a time; req deasserts the cycle after ack is sampled.

## Timing
- Reset (async, any state, including mid-handshake): state FETCH, PC 0, registers 0, out 0, done 0, imem_req/dmem_req 0 immediately; imem_req rises first clock after reset release.
- Zero-wait latency (ack same cycle as req): R-type/addi 4 cycles, lw 5, sw 4, beq 3, j 2, halt 2 then HALT, no-op 2.
- Each wait cycle (req high, ack low) adds one cycle; addr/we/wdata stable throughout.
- ack while req low is ignored.
- out changes only on WB clock edge; done rises on the edge entering HALT.

## Test plan
- Reset: drive reset low mid-MEM with dmem_req high -> dmem_req, out, done, PC drop to 0 asynchronously; first fetch at addr 0 after release.
- Arithmetic: addi r1,r0,5; addi r2,r0,-3; add r3,r1,r2; slt r4,r2,r1 -> out sequence 5, 0xFFFD, 2, 1; R-type 4 cycles each with zero-wait memory.
- Memory with waits: sw r1,4(r0) then lw r5,4(r0), dmem_ack delayed 3 cycles -> dmem_addr 4, wdata 5, out 5; lw takes 8 cycles.
- Control flow: beq r1,r1,-1 loop checked taken twice; j 0x3FF then sequential fetch -> addr 0x3FF then wrap to 0x000.
- r0/unknown: addi r0,r0,7 and opcode 0x3E -> out unchanged, r0 reads 0, PC advances by 1 each.
- Halt/params: halt at addr 6 -> done high after 2 cycles, no further imem_req for 20 cycles; rerun arithmetic with DATA_W=32, NREG=32 -> add of 0x7FFFFFFF+1 gives 0x80000000.

Source files
------------

// File: rtl/mc_core_if.sv
// Instruction and data memory ports of mc_core, each a req/ack handshake.
// The core is the master; memories may stretch a request with wait states.
interface mc_core_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 10
);
    logic              imem_req;
    logic [ADDR_W-1:0] imem_addr;
    logic              imem_ack;
    logic [31:0]       imem_rdata;
    logic              dmem_req;
    logic              dmem_we;
    logic [ADDR_W-1:0] dmem_addr;
    logic [DATA_W-1:0] dmem_wdata;
    logic              dmem_ack;
    logic [DATA_W-1:0] dmem_rdata;

    modport master (
        output imem_req, imem_addr, dmem_req, dmem_we, dmem_addr, dmem_wdata,
        input  imem_ack, imem_rdata, dmem_ack, dmem_rdata
    );

    modport slave (
        input  imem_req, imem_addr, dmem_req, dmem_we, dmem_addr, dmem_wdata,
        output imem_ack, imem_rdata, dmem_ack, dmem_rdata
    );
endinterface

// File: rtl/mc_core.sv
// Multicycle MIPS-subset core: FSM, register file, ALU and PC sequencing.
// `out` mirrors the last register write-back; `done` is sticky after HALT.
module mc_core #(
    parameter int DATA_W = 16,
    parameter int NREG   = 8,
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              reset,
    mc_core_if.master         bus,
    output logic [DATA_W-1:0] out,
    output logic              done
);
    localparam int RW = $clog2(NREG);

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_HALT  = 6'h3F;
    localparam logic [5:0] FN_ADD   = 6'h20;
    localparam logic [5:0] FN_SUB   = 6'h22;
    localparam logic [5:0] FN_AND   = 6'h24;
    localparam logic [5:0] FN_OR    = 6'h25;
    localparam logic [5:0] FN_SLT   = 6'h2A;

    typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT} state_t;

    state_t                    r_state;
    logic [31:0]               r_ir;
    logic [ADDR_W-1:0]         r_pc;
    logic signed [DATA_W-1:0]  r_a;
    logic signed [DATA_W-1:0]  r_b;
    logic [DATA_W-1:0]         r_res;
    logic [DATA_W-1:0]         r_regs [NREG];
    logic                      r_imem_req;
    logic                      r_dmem_req;
    logic                      r_dmem_we;
    logic [ADDR_W-1:0]         r_dmem_addr;
    logic [DATA_W-1:0]         r_dmem_wdata;
    logic [DATA_W-1:0]         r_out;
    logic                      r_done;

    logic [5:0]                w_op;
    logic [5:0]                w_fn;
    logic [RW-1:0]             w_rs;
    logic [RW-1:0]             w_rt;
    logic [RW-1:0]             w_rd;
    logic [RW-1:0]             w_wdst;
    logic signed [DATA_W-1:0]  w_imm;
    logic                      w_unused_ir;

    assign w_op        = r_ir[31:26];
    assign w_fn        = r_ir[5:0];
    assign w_rs        = r_ir[21 +: RW];
    assign w_rt        = r_ir[16 +: RW];
    assign w_rd        = r_ir[11 +: RW];
    assign w_wdst      = (w_op == OP_RTYPE) ? w_rd : w_rt;
    assign w_imm       = DATA_W'($signed(r_ir[15:0]));
    assign w_unused_ir = ^r_ir;

    function automatic logic f_fn_known(input logic [5:0] fn);
        return (fn == FN_ADD) || (fn == FN_SUB) || (fn == FN_AND) ||
               (fn == FN_OR)  || (fn == FN_SLT);
    endfunction

    function automatic logic [DATA_W-1:0] f_alu(input logic [5:0] fn,
                                                input logic signed [DATA_W-1:0] a,
                                                input logic signed [DATA_W-1:0] b);
        case (fn)
            FN_ADD:  return a + b;
            FN_SUB:  return a - b;
            FN_AND:  return a & b;
            FN_OR:   return a | b;
            FN_SLT:  return (a < b) ? DATA_W'(1) : '0;
            default: return '0;
        endcase
    endfunction

    // Every transition back to FETCH raises imem_req on the same edge, so a
    // zero-wait fetch costs one cycle; only the first fetch after reset waits one.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= S_FETCH;
            r_ir         <= '0;
            r_pc         <= '0;
            r_a          <= '0;
            r_b          <= '0;
            r_res        <= '0;
            r_imem_req   <= 1'b0;
            r_dmem_req   <= 1'b0;
            r_dmem_we    <= 1'b0;
            r_dmem_addr  <= '0;
            r_dmem_wdata <= '0;
            r_out        <= '0;
            r_done       <= 1'b0;
            for (int i = 0; i < NREG; i++) r_regs[i] <= '0;
        end else begin
            case (r_state)
                S_FETCH: begin
                    if (!r_imem_req) begin
                        r_imem_req <= 1'b1;
                    end else if (bus.imem_ack) begin
                        r_ir       <= bus.imem_rdata;
                        r_pc       <= r_pc + ADDR_W'(1);
                        r_imem_req <= 1'b0;
                        r_state    <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    r_a <= r_regs[w_rs];
                    r_b <= r_regs[w_rt];
                    case (w_op)
                        OP_J: begin
                            r_pc       <= ADDR_W'(r_ir[25:0]);
                            r_imem_req <= 1'b1;
                            r_state    <= S_FETCH;
                        end
                        OP_HALT: begin
                            r_done  <= 1'b1;
                            r_state <= S_HALT;
                        end
                        OP_ADDI, OP_LW, OP_SW, OP_BEQ: r_state <= S_EXEC;
                        OP_RTYPE: begin
                            if (f_fn_known(w_fn)) begin
                                r_state <= S_EXEC;
                            end else begin
                                r_imem_req <= 1'b1;
                                r_state    <= S_FETCH;
                            end
                        end
                        default: begin
                            r_imem_req <= 1'b1;
                            r_state    <= S_FETCH;
                        end
                    endcase
                end
                S_EXEC: begin
                    case (w_op)
                        OP_BEQ: begin
                            if (r_a == r_b) r_pc <= r_pc + ADDR_W'($signed(r_ir[15:0]));
                            r_imem_req <= 1'b1;
                            r_state    <= S_FETCH;
                        end
                        OP_LW, OP_SW: begin
                            r_dmem_addr  <= ADDR_W'($unsigned(r_a + w_imm));
                            r_dmem_we    <= (w_op == OP_SW);
                            r_dmem_wdata <= r_b;
                            r_dmem_req   <= 1'b1;
                            r_state      <= S_MEM;
                        end
                        OP_ADDI: begin
                            r_res   <= r_a + w_imm;
                            r_state <= S_WB;
                        end
                        default: begin
                            r_res   <= f_alu(w_fn, r_a, r_b);
                            r_state <= S_WB;
                        end
                    endcase
                end
                S_MEM: begin
                    if (bus.dmem_ack) begin
                        r_dmem_req <= 1'b0;
                        if (r_dmem_we) begin
                            r_imem_req <= 1'b1;
                            r_state    <= S_FETCH;
                        end else begin
                            r_res   <= bus.dmem_rdata;
                            r_state <= S_WB;
                        end
                    end
                end
                S_WB: begin
                    if (w_wdst != '0) begin
                        r_regs[w_wdst] <= r_res;
                        r_out          <= r_res;
                    end
                    r_imem_req <= 1'b1;
                    r_state    <= S_FETCH;
                end
                S_HALT: r_state <= S_HALT;
                default: begin
                    r_imem_req <= 1'b0;
                    r_state    <= S_FETCH;
                end
            endcase
        end
    end

    assign bus.imem_req   = r_imem_req;
    assign bus.imem_addr  = r_pc;
    assign bus.dmem_req   = r_dmem_req;
    assign bus.dmem_we    = r_dmem_we;
    assign bus.dmem_addr  = r_dmem_addr;
    assign bus.dmem_wdata = r_dmem_wdata;
    assign out            = r_out;
    assign done           = r_done;
endmodule
